// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, control encodings and forwarding helper for
//               the integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int N_REG      = 32;
   localparam int N_REG_ADDR = 5;
   localparam int REG_NUM    = 32;

   localparam logic [N_REG_ADDR-1:0] NOP_REG_ADDR = '0;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic READ_ENABLE   = 1'b1;
   localparam logic READ_DISABLE  = 1'b0;
   localparam logic RST_ENABLE    = 1'b0;

   // A source only forwards when enabled; the address is ignored otherwise.
   function automatic logic fwd_hit(
      input logic                  wen,
      input logic [N_REG_ADDR-1:0] waddr,
      input logic [N_REG_ADDR-1:0] raddr
   );
      return (wen == WRITE_ENABLE) && (waddr == raddr);
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One read port: enable/zero-register masking, then EX, MEM and
//               WB forwarding ahead of the stored array value.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
   import regfile_pkg::*;
(
   input  logic                  i_re,
   input  logic [N_REG_ADDR-1:0] i_raddr,
   input  logic [N_REG-1:0]      i_arr_data,
   input  logic                  i_ex_wen,
   input  logic [N_REG_ADDR-1:0] i_ex_waddr,
   input  logic [N_REG-1:0]      i_ex_wdata,
   input  logic                  i_mem_wen,
   input  logic [N_REG_ADDR-1:0] i_mem_waddr,
   input  logic [N_REG-1:0]      i_mem_wdata,
   input  logic                  i_wb_wen,
   input  logic [N_REG_ADDR-1:0] i_wb_waddr,
   input  logic [N_REG-1:0]      i_wb_wdata,
   output logic [N_REG-1:0]      o_rdata
);

   logic w_masked;
   logic w_ex_hit;
   logic w_mem_hit;
   logic w_wb_hit;

   assign w_masked  = (i_re != READ_ENABLE) || (i_raddr == NOP_REG_ADDR);
   assign w_ex_hit  = fwd_hit(i_ex_wen,  i_ex_waddr,  i_raddr);
   assign w_mem_hit = fwd_hit(i_mem_wen, i_mem_waddr, i_raddr);
   assign w_wb_hit  = fwd_hit(i_wb_wen,  i_wb_waddr,  i_raddr);

   // Youngest producer wins: EX is newer than MEM, which is newer than WB.
   always_comb begin
      o_rdata = '0;
      if (w_masked) begin
         o_rdata = '0;
      end else if (w_ex_hit) begin
         o_rdata = i_ex_wdata;
      end else if (w_mem_hit) begin
         o_rdata = i_mem_wdata;
      end else if (w_wb_hit) begin
         o_rdata = i_wb_wdata;
      end else begin
         o_rdata = i_arr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : REG_NUM x N_REG register file, one write-back port and two
//               combinational read ports with pipeline forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
   import regfile_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wb_wen,
   input  logic [N_REG_ADDR-1:0] i_wb_waddr,
   input  logic [N_REG-1:0]      i_wb_wdata,
   input  logic                  i_ex_wen,
   input  logic [N_REG_ADDR-1:0] i_ex_waddr,
   input  logic [N_REG-1:0]      i_ex_wdata,
   input  logic                  i_mem_wen,
   input  logic [N_REG_ADDR-1:0] i_mem_waddr,
   input  logic [N_REG-1:0]      i_mem_wdata,
   input  logic                  i_re1,
   input  logic [N_REG_ADDR-1:0] i_raddr1,
   output logic [N_REG-1:0]      o_rdata1,
   input  logic                  i_re2,
   input  logic [N_REG_ADDR-1:0] i_raddr2,
   output logic [N_REG-1:0]      o_rdata2
);

   logic [N_REG-1:0] r_regs [REG_NUM];
   logic             w_wr_en;
   logic [N_REG-1:0] w_arr_data1;
   logic [N_REG-1:0] w_arr_data2;

   assign w_wr_en = (i_wb_wen == WRITE_ENABLE) && (i_wb_waddr != NOP_REG_ADDR);

   generate
      for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
         if (g == NOP_REG_ADDR) begin : g_zero
            always_ff @(posedge i_clk or negedge i_rst_n) begin
               r_regs[g] <= '0;
            end
         end else begin : g_store
            always_ff @(posedge i_clk or negedge i_rst_n) begin
               if (i_rst_n == RST_ENABLE) begin
                  r_regs[g] <= '0;
               end else if (w_wr_en && (i_wb_waddr == N_REG_ADDR'(g))) begin
                  r_regs[g] <= i_wb_wdata;
               end
            end
         end
      end
   endgenerate

   assign w_arr_data1 = r_regs[i_raddr1];
   assign w_arr_data2 = r_regs[i_raddr2];

   regfile_rd_port u_rd_port1 (
      .i_re        (i_re1),
      .i_raddr     (i_raddr1),
      .i_arr_data  (w_arr_data1),
      .i_ex_wen    (i_ex_wen),
      .i_ex_waddr  (i_ex_waddr),
      .i_ex_wdata  (i_ex_wdata),
      .i_mem_wen   (i_mem_wen),
      .i_mem_waddr (i_mem_waddr),
      .i_mem_wdata (i_mem_wdata),
      .i_wb_wen    (i_wb_wen),
      .i_wb_waddr  (i_wb_waddr),
      .i_wb_wdata  (i_wb_wdata),
      .o_rdata     (o_rdata1)
   );

   regfile_rd_port u_rd_port2 (
      .i_re        (i_re2),
      .i_raddr     (i_raddr2),
      .i_arr_data  (w_arr_data2),
      .i_ex_wen    (i_ex_wen),
      .i_ex_waddr  (i_ex_waddr),
      .i_ex_wdata  (i_ex_wdata),
      .i_mem_wen   (i_mem_wen),
      .i_mem_waddr (i_mem_waddr),
      .i_mem_wdata (i_mem_wdata),
      .i_wb_wen    (i_wb_wen),
      .i_wb_waddr  (i_wb_waddr),
      .i_wb_wdata  (i_wb_wdata),
      .o_rdata     (o_rdata2)
   );

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile
// Description : Directed self-checking bench for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile;
   import regfile_pkg::*;

   logic                  i_clk;
   logic                  i_rst_n;
   logic                  i_wb_wen;
   logic [N_REG_ADDR-1:0] i_wb_waddr;
   logic [N_REG-1:0]      i_wb_wdata;
   logic                  i_ex_wen;
   logic [N_REG_ADDR-1:0] i_ex_waddr;
   logic [N_REG-1:0]      i_ex_wdata;
   logic                  i_mem_wen;
   logic [N_REG_ADDR-1:0] i_mem_waddr;
   logic [N_REG-1:0]      i_mem_wdata;
   logic                  i_re1;
   logic [N_REG_ADDR-1:0] i_raddr1;
   logic [N_REG-1:0]      o_rdata1;
   logic                  i_re2;
   logic [N_REG_ADDR-1:0] i_raddr2;
   logic [N_REG-1:0]      o_rdata2;

   int pass_cnt  = 0;
   int total_cnt = 0;

   regfile dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wb_wen    (i_wb_wen),
      .i_wb_waddr  (i_wb_waddr),
      .i_wb_wdata  (i_wb_wdata),
      .i_ex_wen    (i_ex_wen),
      .i_ex_waddr  (i_ex_waddr),
      .i_ex_wdata  (i_ex_wdata),
      .i_mem_wen   (i_mem_wen),
      .i_mem_waddr (i_mem_waddr),
      .i_mem_wdata (i_mem_wdata),
      .i_re1       (i_re1),
      .i_raddr1    (i_raddr1),
      .o_rdata1    (o_rdata1),
      .i_re2       (i_re2),
      .i_raddr2    (i_raddr2),
      .o_rdata2    (o_rdata2)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic idle_inputs();
      i_wb_wen    = WRITE_DISABLE;
      i_wb_waddr  = '0;
      i_wb_wdata  = '0;
      i_ex_wen    = WRITE_DISABLE;
      i_ex_waddr  = '0;
      i_ex_wdata  = '0;
      i_mem_wen   = WRITE_DISABLE;
      i_mem_waddr = '0;
      i_mem_wdata = '0;
      i_re1       = READ_ENABLE;
      i_raddr1    = '0;
      i_re2       = READ_ENABLE;
      i_raddr2    = '0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      idle_inputs();
      i_raddr1 = 5'd5;
      i_raddr2 = 5'd31;
      repeat (2) @(negedge i_clk);
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h0 || o_rdata2 !== 32'h0)
         $display("FAIL reset_hold: rdata1=%h rdata2=%h expected 0", o_rdata1, o_rdata2);
      else pass_cnt++;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      for (int i = 0; i < REG_NUM; i++) begin
         i_raddr1 = N_REG_ADDR'(i);
         i_raddr2 = N_REG_ADDR'(REG_NUM - 1 - i);
         #0.1;
         total_cnt++;
         if (o_rdata1 !== 32'h0 || o_rdata2 !== 32'h0)
            $display("FAIL reset_read r%0d/r%0d: rdata1=%h rdata2=%h expected 0",
                     i, REG_NUM - 1 - i, o_rdata1, o_rdata2);
         else pass_cnt++;
      end
   endtask

   task automatic test_wb_write();
      @(negedge i_clk);
      idle_inputs();
      i_wb_wen = WRITE_ENABLE; i_wb_waddr = 5'd5; i_wb_wdata = 32'h12345678;
      @(negedge i_clk);
      i_wb_wen = WRITE_DISABLE;
      i_raddr1 = 5'd5;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h12345678)
         $display("FAIL wb_write_r5: got %h expected 12345678", o_rdata1);
      else pass_cnt++;
      i_wb_wen = WRITE_ENABLE; i_wb_waddr = 5'd0; i_wb_wdata = 32'hFFFFFFFF;
      i_raddr1 = 5'd0;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h0)
         $display("FAIL wb_r0_bypass: got %h expected 0", o_rdata1);
      else pass_cnt++;
      @(negedge i_clk);
      i_wb_wen = WRITE_DISABLE;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h0)
         $display("FAIL wb_r0_stored: got %h expected 0", o_rdata1);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle_bypass();
      @(negedge i_clk);
      idle_inputs();
      i_wb_wen = WRITE_ENABLE; i_wb_waddr = 5'd7; i_wb_wdata = 32'hA5A5A5A5;
      i_raddr2 = 5'd7;
      i_raddr1 = 5'd7;
      #1;
      total_cnt++;
      if (o_rdata2 !== 32'hA5A5A5A5 || o_rdata1 !== 32'hA5A5A5A5)
         $display("FAIL wb_bypass_r7: rdata1=%h rdata2=%h expected a5a5a5a5", o_rdata1, o_rdata2);
      else pass_cnt++;
      @(negedge i_clk);
      i_wb_wen = WRITE_DISABLE;
      #1;
      total_cnt++;
      if (o_rdata2 !== 32'hA5A5A5A5)
         $display("FAIL wb_stored_r7: got %h expected a5a5a5a5", o_rdata2);
      else pass_cnt++;
   endtask

   task automatic test_priority();
      @(negedge i_clk);
      idle_inputs();
      i_raddr1 = 5'd3;
      i_raddr2 = 5'd3;
      i_ex_wen  = WRITE_ENABLE; i_ex_waddr  = 5'd3; i_ex_wdata  = 32'h1;
      i_mem_wen = WRITE_ENABLE; i_mem_waddr = 5'd3; i_mem_wdata = 32'h2;
      i_wb_wen  = WRITE_ENABLE; i_wb_waddr  = 5'd3; i_wb_wdata  = 32'h3;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h1 || o_rdata2 !== 32'h1)
         $display("FAIL prio_ex: rdata1=%h rdata2=%h expected 1", o_rdata1, o_rdata2);
      else pass_cnt++;
      i_ex_wen = WRITE_DISABLE;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h2 || o_rdata2 !== 32'h2)
         $display("FAIL prio_mem: rdata1=%h rdata2=%h expected 2", o_rdata1, o_rdata2);
      else pass_cnt++;
      i_mem_wen = WRITE_DISABLE;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h3 || o_rdata2 !== 32'h3)
         $display("FAIL prio_wb: rdata1=%h rdata2=%h expected 3", o_rdata1, o_rdata2);
      else pass_cnt++;
      // EX-only forward to r10 across an edge must not land in storage.
      @(negedge i_clk);
      idle_inputs();
      i_ex_wen = WRITE_ENABLE; i_ex_waddr = 5'd10; i_ex_wdata = 32'hCAFEF00D;
      i_mem_wen = WRITE_ENABLE; i_mem_waddr = 5'd11; i_mem_wdata = 32'h0BADBEEF;
      i_raddr1 = 5'd10;
      i_raddr2 = 5'd11;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'hCAFEF00D || o_rdata2 !== 32'h0BADBEEF)
         $display("FAIL fwd_split: rdata1=%h rdata2=%h expected cafef00d/0badbeef",
                  o_rdata1, o_rdata2);
      else pass_cnt++;
      @(negedge i_clk);
      i_ex_wen  = WRITE_DISABLE;
      i_mem_wen = WRITE_DISABLE;
      i_raddr2  = 5'd3;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h0 || o_rdata2 !== 32'h3)
         $display("FAIL fwd_no_store: r10=%h r3=%h expected 0/3", o_rdata1, o_rdata2);
      else pass_cnt++;
   endtask

   task automatic test_disabled_paths();
      @(negedge i_clk);
      idle_inputs();
      i_re1 = READ_DISABLE;
      i_raddr1 = 5'd5;
      i_raddr2 = 5'd5;
      i_ex_wen = WRITE_DISABLE; i_ex_waddr = 5'd5; i_ex_wdata = 32'hDEAD;
      i_mem_wen = WRITE_DISABLE; i_mem_waddr = 5'd5; i_mem_wdata = 32'hBEEF;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h0)
         $display("FAIL re1_off: got %h expected 0", o_rdata1);
      else pass_cnt++;
      total_cnt++;
      if (o_rdata2 !== 32'h12345678)
         $display("FAIL fwd_wen_off: got %h expected 12345678", o_rdata2);
      else pass_cnt++;
      i_re2 = READ_DISABLE;
      i_ex_wen = WRITE_ENABLE;
      #1;
      total_cnt++;
      if (o_rdata2 !== 32'h0)
         $display("FAIL re2_off_fwd: got %h expected 0", o_rdata2);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      @(negedge i_clk);
      idle_inputs();
      for (int i = 1; i < REG_NUM; i++) begin
         i_wb_wen = WRITE_ENABLE; i_wb_waddr = N_REG_ADDR'(i); i_wb_wdata = N_REG'(i);
         @(negedge i_clk);
      end
      i_wb_wen = WRITE_DISABLE;
      i_raddr1 = 5'd17;
      i_raddr2 = 5'd31;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'd17 || o_rdata2 !== 32'd31)
         $display("FAIL fill: r17=%h r31=%h expected 11/1f", o_rdata1, o_rdata2);
      else pass_cnt++;
      // Reset lands between edges with a write pending to r4.
      i_wb_wen = WRITE_ENABLE; i_wb_waddr = 5'd4; i_wb_wdata = 32'h44444444;
      #1;
      i_rst_n = 1'b0;
      i_wb_wen = WRITE_DISABLE;
      for (int i = 0; i < REG_NUM; i++) begin
         i_raddr1 = N_REG_ADDR'(i);
         i_raddr2 = N_REG_ADDR'(i);
         #0.05;
         total_cnt++;
         if (o_rdata1 !== 32'h0 || o_rdata2 !== 32'h0)
            $display("FAIL async_rst r%0d: rdata1=%h rdata2=%h expected 0", i, o_rdata1, o_rdata2);
         else pass_cnt++;
      end
      i_wb_wen = WRITE_ENABLE; i_wb_waddr = 5'd4; i_wb_wdata = 32'h44444444;
      @(negedge i_clk);
      i_wb_wen = WRITE_DISABLE;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      i_raddr1 = 5'd4;
      i_raddr2 = 5'd20;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h0 || o_rdata2 !== 32'h0)
         $display("FAIL post_rst: r4=%h r20=%h expected 0", o_rdata1, o_rdata2);
      else pass_cnt++;
      // First edge after release must take a write.
      i_rst_n = 1'b0;
      #1;
      i_wb_wen = WRITE_ENABLE; i_wb_waddr = 5'd9; i_wb_wdata = 32'h9;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      i_wb_wen = WRITE_DISABLE;
      i_raddr1 = 5'd9;
      #1;
      total_cnt++;
      if (o_rdata1 !== 32'h9)
         $display("FAIL first_edge_write: got %h expected 9", o_rdata1);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_wb_write();
      test_same_cycle_bypass();
      test_priority();
      test_disabled_paths();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL have these ports, in this order:
  - i_clk  input  1  clock; all state updates on the rising edge.
  - i_rst_n  input  1  reset, asynchronous, active-low.
  - i_wb_wen  input  1  write-back write enable.
  - i_wb_waddr  input  N_REG_ADDR  write-back destination register.
  - i_wb_wdata  input  N_REG  write-back data.
  - i_ex_wen / i_ex_waddr / i_ex_wdata  input  1/N_REG_ADDR/N_REG  EX-stage result, used for forwarding.
  - i_mem_wen / i_mem_waddr / i_mem_wdata  input  1/N_REG_ADDR/N_REG  MEM-stage result, used for forwarding (fed by the EX/MEM pipeline register outputs).
  - i_re1  input  1  read port 1 enable.
  - i_raddr1  input  N_REG_ADDR  read port 1 address.
  - o_rdata1  output  N_REG  read port 1 data.
  - i_re2  input  1  read port 2 enable.
  - i_raddr2  input  N_REG_ADDR  read port 2 address.
  - o_rdata2  output  N_REG  read port 2 data.
REQ-002 Reset i_rst_n SHALL be asynchronous and active-low; the clock SHALL be i_clk.
REQ-003 Parameters SHALL come from the shared package, not be local:
  - N_REG = 32, data width.
  - N_REG_ADDR = 5, address width.
  - REG_NUM = 32, register count.
  - NOP_REG_ADDR = 0, the zero register.

Function
REQ-004 Storage SHALL be REG_NUM x N_REG flip-flops.
REQ-005 Write SHALL occur on the rising edge of i_clk when i_wb_wen = 1 and i_wb_waddr != 0; the write takes effect in one cycle.
REQ-006 A write to register 0 SHALL be discarded; register 0 SHALL always read as 0.
REQ-007 Reads SHALL be combinational (zero latency), each port resolved independently.
REQ-008 Read-port priority, highest first:
  - (a) re = 0 -> 0.
  - (b) raddr = 0 -> 0.
  - (c) i_ex_wen and i_ex_waddr == raddr -> i_ex_wdata.
  - (d) i_mem_wen and i_mem_waddr == raddr -> i_mem_wdata.
  - (e) i_wb_wen and i_wb_waddr == raddr -> i_wb_wdata (same-cycle write bypass).
  - (f) stored array value.
REQ-009 When EX, MEM and WB all target the same register in one cycle, the EX value SHALL win on both ports.
REQ-010 Both read ports SHALL be able to address the same register in one cycle and return identical data.
REQ-011 A forwarding source with wen = 0 SHALL be ignored regardless of its address or data.
REQ-012 Forwarding SHALL NOT modify storage; only the WB port writes the array.
REQ-013 Inputs that are X on a disabled path (wen = 0 or re = 0) SHALL NOT propagate to outputs.

Reset
REQ-014 While i_rst_n = 0, all REG_NUM entries SHALL clear to 0, asynchronously.
REQ-015 During reset, o_rdata1 and o_rdata2 SHALL read 0 unless a forwarding path is active: forwarding stays combinational, and upstream stages are themselves held in their NOP state during reset.
REQ-016 A write coincident with reset assertion SHALL be lost.
REQ-017 After reset deasserts, the first rising edge SHALL accept writes normally.

Structure
REQ-018 The following SHALL live in the shared defines package:
  - N_REG, N_REG_ADDR, REG_NUM, NOP_REG_ADDR.
  - WRITE_ENABLE / WRITE_DISABLE, READ_ENABLE / READ_DISABLE.
  - RST_ENABLE (= 0).
REQ-019 The per-port forwarding/priority mux SHALL be one sub-module, regfile_rd_port, instantiated twice; storage and write logic SHALL stay in regfile.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - Reset then read all 32 registers on both ports -> every read returns 0x00000000.
  - WB write r5 = 0x12345678; next cycle read port 1 r5 -> 0x12345678. Write r0 = 0xFFFFFFFF; read r0 -> 0.
  - Same-cycle WB write r7 = 0xA5A5A5A5 while port 2 reads r7 -> 0xA5A5A5A5 that cycle; array holds it after the edge.
  - EX r3 = 0x1, MEM r3 = 0x2, WB r3 = 0x3 simultaneously; both ports read r3 -> 0x1. With EX wen dropped -> 0x2. With MEM also dropped -> 0x3.
  - i_re1 = 0 with raddr1 = r5 (holding 0x12345678) -> o_rdata1 = 0. EX wen = 0 with matching address and data 0xDEAD -> no forward.
  - Fill r1..r31 with their own index, assert i_rst_n = 0 mid-sequence asynchronously -> all reads 0 immediately, and remain 0 after release until rewritten.
